// File: rtl/coincidence_gate_counter.sv
// Two-channel photon counter: counts singles A, B and windowed A/B coincidences
// over a programmable gate, then latches the three counts.
`default_nettype none

module coincidence_gate_counter #(
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 4,
  parameter int GATE_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_a,
  input  logic              pulse_b,
  input  logic [WIN_W-1:0]  window,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic [CNT_W-1:0]  count_a,
  output logic [CNT_W-1:0]  count_b,
  output logic [CNT_W-1:0]  count_ab,
  output logic              overflow,
  output logic              result_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    LATCH     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state, state_nx;
  logic                load_timer;
  logic [GATE_W-1:0]   timer;
  logic [GATE_W-1:0]   gate_load;
  logic [CNT_W-1:0]    work_a, work_b, work_ab;
  logic                work_ovf;
  logic [WIN_W-1:0]    win_a, win_b;
  logic                counting;
  logic                coinc;

  assign gate_load = (gate_len == '0) ? GATE_W'(1) : gate_len;
  assign busy      = (state != IDLE);
  assign counting  = (state == INTEGRATE) && !abort;
  assign coinc     = counting && ((pulse_a && pulse_b) ||
                                  (pulse_a && (win_b != '0)) ||
                                  (pulse_b && (win_a != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_timer = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = INTEGRATE;
          load_timer = 1'b1;
        end
      end
      INTEGRATE: begin
        if (timer <= GATE_W'(1)) state_nx = LATCH;
      end
      LATCH: begin
        if (continuous) begin
          state_nx   = INTEGRATE;
          load_timer = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides every other transition, including a continuous restart.
    if (abort && state != IDLE) begin
      state_nx   = IDLE;
      load_timer = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      work_a       <= '0;
      work_b       <= '0;
      work_ab      <= '0;
      work_ovf     <= 1'b0;
      win_a        <= '0;
      win_b        <= '0;
      count_a      <= '0;
      count_b      <= '0;
      count_ab     <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;

      if (load_timer)
        timer <= gate_load;
      else if (state == INTEGRATE && timer != '0)
        timer <= timer - GATE_W'(1);

      if (state == LATCH && !abort) begin
        count_a      <= work_a;
        count_b      <= work_b;
        count_ab     <= work_ab;
        overflow     <= work_ovf;
        result_valid <= 1'b1;
      end

      if (counting) begin
        if (pulse_a) begin
          if (work_a == CNT_MAX) work_ovf <= 1'b1;
          else                   work_a   <= work_a + CNT_W'(1);
        end
        if (pulse_b) begin
          if (work_b == CNT_MAX) work_ovf <= 1'b1;
          else                   work_b   <= work_b + CNT_W'(1);
        end
        if (coinc) begin
          if (work_ab == CNT_MAX) work_ovf <= 1'b1;
          else                    work_ab  <= work_ab + CNT_W'(1);
        end
        // A paired pulse clears both windows so it cannot pair a second time.
        if (coinc) begin
          win_a <= '0;
          win_b <= '0;
        end else begin
          if (pulse_a)           win_a <= window;
          else if (win_a != '0)  win_a <= win_a - WIN_W'(1);
          if (pulse_b)           win_b <= window;
          else if (win_b != '0)  win_b <= win_b - WIN_W'(1);
        end
      end else begin
        work_a   <= '0;
        work_b   <= '0;
        work_ab  <= '0;
        work_ovf <= 1'b0;
        win_a    <= '0;
        win_b    <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coincidence_gate_counter.sv
// Scoreboard bench for coincidence_gate_counter (CNT_W=4 so saturation is reachable).
`default_nettype none

module tb_coincidence_gate_counter;

  localparam int CNT_W  = 4;
  localparam int WIN_W  = 4;
  localparam int GATE_W = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pulse_a = 1'b0, pulse_b = 1'b0;
  logic [WIN_W-1:0]  window = '0;
  logic [GATE_W-1:0] gate_len = '0;
  logic              start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic [CNT_W-1:0]  count_a, count_b, count_ab;
  logic              overflow, result_valid, busy;

  typedef struct {
    int a;
    int b;
    int ab;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   strobe_cyc[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  coincidence_gate_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .GATE_W(GATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_a(pulse_a), .pulse_b(pulse_b),
    .window(window), .gate_len(gate_len), .start(start),
    .continuous(continuous), .abort(abort),
    .count_a(count_a), .count_b(count_b), .count_ab(count_ab),
    .overflow(overflow), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      strobe_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("count_a",  int'(count_a),  e.a);
        chk("count_b",  int'(count_b),  e.b);
        chk("count_ab", int'(count_ab), e.ab);
        chk("overflow", int'(overflow), e.ovf);
      end
    end
  end

  // Mask bit c-1 drives the pulse in INTEGRATE cycle c.
  task automatic run_gate(input int glen, input int ncyc, input int win,
                          input logic [31:0] ma, input logic [31:0] mb,
                          input int ea, input int eb, input int eab, input int eovf);
    exp_t e;
    e.a = ea; e.b = eb; e.ab = eab; e.ovf = eovf;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; gate_len = GATE_W'(glen); window = WIN_W'(win);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      pulse_a = ma[c];
      pulse_b = mb[c];
      @(posedge clk); #1;
    end
    pulse_a = 1'b0; pulse_b = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("missing_strobe", sb.size(), 0);
    chk("busy_after_gate", int'(busy), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    chk("reset_count_a", int'(count_a), 0);
    chk("reset_valid", int'(result_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ovf", int'(overflow), 0);
    @(negedge clk); rst_n = 1'b1;

    // singles only, no pair within window 2
    run_gate(10, 10, 2, 32'h12, 32'h100, 2, 1, 0, 0);
    // B two cycles after A pairs once; a later B does not re-pair
    run_gate(10, 10, 3, 32'h8, 32'h60, 1, 2, 1, 0);
    // B four cycles after A is outside window 3
    run_gate(10, 10, 3, 32'h8, 32'h80, 1, 1, 0, 0);
    // window 0: only same-cycle pairs
    run_gate(10, 10, 0, 32'h2A, 32'h2A, 3, 3, 3, 0);
    // A two cycles after B, window 2
    run_gate(10, 10, 2, 32'h10, 32'h4, 1, 1, 1, 0);
    // window 0 with offset pulses: no pair
    run_gate(10, 10, 0, 32'h1, 32'h2, 1, 1, 0, 0);

    // continuous mode, pulse_a held high including the LATCH cycles
    begin
      exp_t e;
      e.a = 5; e.b = 0; e.ab = 0; e.ovf = 0;
      repeat (3) sb.push_back(e);
      strobe_cyc.delete();
      @(posedge clk); #1;
      start = 1'b1; gate_len = GATE_W'(5); window = '0; continuous = 1'b1; pulse_a = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1 continuous = 1'b0;
      repeat (4) @(posedge clk);
      #1 pulse_a = 1'b0;
      @(negedge clk); #1;
      chk("cont_strobes", strobe_cyc.size(), 3);
      if (strobe_cyc.size() == 3) begin
        chk("cont_period1", strobe_cyc[1] - strobe_cyc[0], 6);
        chk("cont_period2", strobe_cyc[2] - strobe_cyc[1], 6);
      end
      chk("cont_pending", sb.size(), 0);
      sb.delete();
      repeat (3) @(posedge clk);
      #1 chk("cont_stopped", int'(busy), 0);
    end

    // abort after three pulses: no strobe, latched values kept
    @(posedge clk); #1;
    start = 1'b1; gate_len = GATE_W'(10);
    @(posedge clk); #1;
    start = 1'b0; pulse_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 pulse_a = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", int'(busy), 0);
    repeat (14) @(posedge clk);
    #1 chk("abort_keep_a", int'(count_a), 5);
    run_gate(10, 10, 2, 32'h4, 32'h0, 1, 0, 0, 0);

    // gate_len 0 behaves as a one-cycle gate
    run_gate(0, 1, 2, 32'h1, 32'h0, 1, 0, 0, 0);
    // saturation at 15 with overflow
    run_gate(24, 24, 2, 32'h000FFFFF, 32'h0, 15, 0, 0, 1);

    // asynchronous reset mid-gate
    @(posedge clk); #1;
    start = 1'b1; gate_len = GATE_W'(10);
    @(posedge clk); #1;
    start = 1'b0; pulse_a = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    pulse_a = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_gate(6, 6, 1, 32'h1, 32'h2, 1, 1, 1, 0);

    repeat (3) @(posedge clk);
    #1 chk("final_pending", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
